// File: rtl/float_pkg.sv
// Shared field layout, special values and accumulator state encoding for the
// 8-bit unsigned float format (value = M * 2^E).
package float_pkg;

   localparam int EXP_MSB = 7;
   localparam int EXP_LSB = 5;
   localparam int MAN_MSB = 4;
   localparam int MAN_LSB = 0;
   localparam int EXP_W   = EXP_MSB - EXP_LSB + 1;
   localparam int MAN_W   = MAN_MSB - MAN_LSB + 1;

   localparam logic [7:0] FLOAT_MAX  = 8'hFF;
   localparam logic [7:0] FLOAT_ZERO = 8'h00;

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_ADD    = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/float_accum_if.sv
// Operand stream in, frame result out; the producer/consumer side uses
// master, the accumulator uses slave.
interface float_accum_if #(
   parameter int CNT_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_sat;
   logic             out_trunc;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_sat, out_trunc
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_sat, out_trunc
   );
endinterface

// File: rtl/float_add.sv
// Combinational float adder: align to the larger exponent (smaller mantissa
// truncated), add, renormalise on carry, saturate to FLOAT_MAX on overflow.
module float_add
   import float_pkg::*;
(
   input  logic [7:0] aIn,
   input  logic [7:0] bIn,
   output logic [7:0] result
);

   logic [EXP_W-1:0] exp_a;
   logic [EXP_W-1:0] exp_b;
   logic [MAN_W-1:0] man_a;
   logic [MAN_W-1:0] man_b;
   logic [EXP_W-1:0] big_exp;
   logic [MAN_W-1:0] big_man;
   logic [MAN_W-1:0] small_man;
   logic [MAN_W:0]   man_sum;

   always_comb begin
      exp_a = aIn[EXP_MSB:EXP_LSB];
      exp_b = bIn[EXP_MSB:EXP_LSB];
      man_a = aIn[MAN_MSB:MAN_LSB];
      man_b = bIn[MAN_MSB:MAN_LSB];

      if (exp_a >= exp_b) begin
         big_exp   = exp_a;
         big_man   = man_a;
         small_man = man_b >> (exp_a - exp_b);
      end else begin
         big_exp   = exp_b;
         big_man   = man_b;
         small_man = man_a >> (exp_b - exp_a);
      end

      man_sum = {1'b0, big_man} + {1'b0, small_man};
      result  = {big_exp, man_sum[MAN_W-1:0]};

      // Two 5-bit mantissas carry at most one bit, so one right shift suffices.
      if (man_sum[MAN_W]) begin
         if (big_exp == {EXP_W{1'b1}}) begin
            result = FLOAT_MAX;
         end else begin
            result = {big_exp + {{(EXP_W-1){1'b0}}, 1'b1}, man_sum[MAN_W:1]};
         end
      end
   end

endmodule

// File: rtl/float_accum.sv
// Frame accumulator: sums a framed operand stream with one float_add and
// presents sum, term count and saturation/truncation flags per frame.
module float_accum
   import float_pkg::*;
#(
   parameter int MAX_TERMS = 16,
   parameter int CNT_W     = 5
) (
   input  logic clk,
   input  logic reset_n,
   float_accum_if.slave bus
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_reg, state_next;
   logic [7:0]       op_reg, op_next;
   logic             last_reg, last_next;
   logic [7:0]       acc_reg, acc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             sat_reg, sat_next;
   logic             trunc_reg, trunc_next;

   logic [7:0]       sum;
   logic             in_ready;
   logic             out_valid;

   float_add u_add (
      .aIn    (acc_reg),
      .bIn    (op_reg),
      .result (sum)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_ACCEPT;
         op_reg    <= FLOAT_ZERO;
         last_reg  <= 1'b0;
         acc_reg   <= FLOAT_ZERO;
         cnt_reg   <= '0;
         sat_reg   <= 1'b0;
         trunc_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         last_reg  <= last_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         sat_reg   <= sat_next;
         trunc_reg <= trunc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      last_next  = last_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      sat_next   = sat_reg;
      trunc_next = trunc_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;

      case (state_reg)
         ST_ACCEPT: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               op_next    = bus.in_data;
               last_next  = bus.in_last;
               state_next = ST_ADD;
            end
         end
         ST_ADD: begin
            acc_next = sum;
            cnt_next = cnt_reg + CNT_ONE;
            sat_next = sat_reg | (sum == FLOAT_MAX);
            if (last_reg) begin
               state_next = ST_DONE;
            end else if (cnt_reg + CNT_ONE == MAX_CNT) begin
               trunc_next = 1'b1;
               state_next = ST_DONE;
            end else begin
               state_next = ST_ACCEPT;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               acc_next   = FLOAT_ZERO;
               cnt_next   = '0;
               sat_next   = 1'b0;
               trunc_next = 1'b0;
               state_next = ST_ACCEPT;
            end
         end
         default: begin
            state_next = ST_ACCEPT;
         end
      endcase
   end

   // Handshake outputs decode state only; result fields come straight from registers.
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_sum   = acc_reg;
   assign bus.out_count = cnt_reg;
   assign bus.out_sat   = sat_reg;
   assign bus.out_trunc = trunc_reg;

endmodule
